rom_menu_ctrl: RTL and testbench
================================

// Module: rom_menu_ctrl
// PURPOSE
//  Upstream controller for the ROM loader: turns debounced menu key levels into a
//  16-bit ROM index (selectedROM) and a held load request (doLoadRom). The loader
//  enters its wait state while doLoadRom=1 and latches selectedROM on its fall.
//  Supports hold-to-autorepeat navigation and wrap-around over NUM_ROMS entries.
// PARAMETERS
//  NUM_ROMS      16'd256  number of selectable ROMs; valid index range 0..NUM_ROMS-1 (>=1)
//  LOAD_CYCLES   16'd64   clk cycles doLoadRom is held high (>=16: loader samples at clk/4)
//  REPEAT_DELAY  24'd8000000  clk cycles a nav key is held before autorepeat starts
//  REPEAT_RATE   24'd2000000  clk cycles between autorepeat steps
// PORTS
//  clk            in   1   system clock (same clock that drives the loader's clk)
//  rst_n          in   1   asynchronous active-low reset
//  key_up         in   1   level, debounced: next ROM (+1)
//  key_down       in   1   level, debounced: previous ROM (-1)
//  key_pgup       in   1   level, debounced: +16
//  key_pgdn       in   1   level, debounced: -16
//  key_enter      in   1   level, debounced: request load
//  sd_initialized in   1   SD card ready; loads are refused while 0
//  currentROM     in   16  index of ROM last loaded (display only, not used for control)
//  selectedROM    out  16  menu cursor index
//  doLoadRom      out  1   load request, held LOAD_CYCLES cycles
//  load_refused   out  1   1-cycle pulse: enter pressed while sd_initialized=0
//  menu_busy      out  1   1 while state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): selectedROM=0, doLoadRom=0, load_refused=0, menu_busy=0,
//   state=IDLE, counters cleared. Reset mid-load drops doLoadRom immediately.
//  Key edges: internal 1-cycle-delayed copy of each key; press = rising edge.
//  Step arithmetic in 17 bits, result modulo NUM_ROMS:
//   +1: NUM_ROMS-1 -> 0; -1: 0 -> NUM_ROMS-1; +16: (s+16)>=NUM_ROMS -> s+16-NUM_ROMS;
//   -16: s<16 -> s+NUM_ROMS-16 (if NUM_ROMS<16, page keys step by 1 instead).
//  Priority per cycle: enter > up > down > pgup > pgdn; 2+ nav keys held = no step.
//  States:
//   IDLE: enter press & sd_initialized -> LOAD (doLoadRom<=1, cnt<=0);
//         enter press & !sd_initialized -> load_refused pulse, stay IDLE;
//         nav press -> step once (registered, visible next cycle), cnt<=0, -> HOLD.
//   HOLD: nav key still held: cnt++; cnt==REPEAT_DELAY-1 -> step, cnt<=0, -> REPEAT.
//         key released or different key pressed -> IDLE (new key handled next cycle).
//   REPEAT: same as HOLD using REPEAT_RATE; stays in REPEAT while held.
//   LOAD: doLoadRom=1, nav keys ignored, selectedROM frozen; cnt==LOAD_CYCLES-1 ->
//         doLoadRom<=0 -> DRAIN.
//   DRAIN: selectedROM stays frozen 8 cycles (loader latches after fall, clk/4 domain);
//         then wait key_enter=0 -> IDLE. Holding enter never retriggers a load.
//  sd_initialized falling during LOAD: pulse completes unchanged (loader handles abort).
//  All outputs registered; step latency 1 cycle from key edge.
// CONFIGURATION
//  ROM_MENU_BCD_EN defined: adds outputs bcd_digits[19:0] (5 BCD digits of
//   selectedROM) and bcd_valid; iterative double-dabble, 16 shift cycles restarted
//   on every selectedROM change; bcd_valid=0 during conversion, 1 after; reset: 0/0.
//  Undefined: ports absent, no converter logic.
// STRUCTURE
//  Package rom_menu_pkg: state encoding (IDLE,HOLD,REPEAT,LOAD,DRAIN), step codes
//   (STEP_P1,STEP_M1,STEP_P16,STEP_M16), DRAIN_CYCLES=8.
//  Sub-module rom_menu_bcd (double-dabble), instantiated only under ROM_MENU_BCD_EN.
// TESTING
//  NUM_ROMS=10, sel=9, pulse key_up -> sel=0 next cycle; pulse key_down -> sel=9.
//  NUM_ROMS=20, sel=10, pulse key_pgup -> sel=6; pulse key_pgdn -> sel=10.
//  REPEAT_DELAY=100, REPEAT_RATE=10, hold key_up 150 cycles from sel=0 -> sel=6.
//  sd_initialized=1, sel=5, enter -> doLoadRom high exactly LOAD_CYCLES cycles,
//   sel=5 held; enter held 500 cycles -> single load only; key_up during LOAD ignored.
//  sd_initialized=0, enter -> load_refused 1-cycle pulse, doLoadRom stays 0.
//  rst_n=0 asserted mid-LOAD -> doLoadRom=0 and sel=0 same cycle (async).

Source files
------------

// File: rtl/rom_menu_pkg.sv
// Shared types and step arithmetic for the ROM menu controller.
// Optional BCD readout is enabled with ROM_MENU_BCD_EN (see rom_menu_ctrl).
package rom_menu_pkg;

  typedef enum logic [2:0] {IDLE, HOLD, REPEAT, LOAD, DRAIN} state_t;
  typedef enum logic [1:0] {STEP_P1, STEP_M1, STEP_P16, STEP_M16} step_t;

  localparam int unsigned DRAIN_CYCLES = 8;

  // 17-bit so s+16 and s+n-16 cannot overflow before the modulo correction
  function automatic logic [15:0] step_rom(input logic [15:0] s, input step_t code,
                                           input logic [15:0] n);
    logic [16:0] s17;
    logic [16:0] n17;
    logic [16:0] t;
    logic        fwd;
    logic        page;
    s17  = {1'b0, s};
    n17  = {1'b0, n};
    fwd  = (code == STEP_P1) || (code == STEP_P16);
    page = ((code == STEP_P16) || (code == STEP_M16)) && (n17 >= 17'd16);
    t    = s17;
    if (fwd) begin
      t = s17 + (page ? 17'd16 : 17'd1);
      if (t >= n17) t = t - n17;
    end else if (page) begin
      t = (s17 < 17'd16) ? (s17 + n17 - 17'd16) : (s17 - 17'd16);
    end else begin
      t = (s17 == 17'd0) ? (n17 - 17'd1) : (s17 - 17'd1);
    end
    return t[15:0];
  endfunction

endpackage

// File: rtl/rom_menu_if.sv
// Key/status bundle between the menu front end and rom_menu_ctrl.
// BCD readout signals exist only when ROM_MENU_BCD_EN is defined.
interface rom_menu_if;
  logic        key_up;
  logic        key_down;
  logic        key_pgup;
  logic        key_pgdn;
  logic        key_enter;
  logic        sd_initialized;
  logic [15:0] currentROM;
  logic [15:0] selectedROM;
  logic        doLoadRom;
  logic        load_refused;
  logic        menu_busy;
`ifdef ROM_MENU_BCD_EN
  logic [19:0] bcd_digits;
  logic        bcd_valid;

  modport master (output key_up, key_down, key_pgup, key_pgdn, key_enter,
                  sd_initialized, currentROM,
                  input  selectedROM, doLoadRom, load_refused, menu_busy,
                  bcd_digits, bcd_valid);
  modport slave  (input  key_up, key_down, key_pgup, key_pgdn, key_enter,
                  sd_initialized, currentROM,
                  output selectedROM, doLoadRom, load_refused, menu_busy,
                  bcd_digits, bcd_valid);
`else
  modport master (output key_up, key_down, key_pgup, key_pgdn, key_enter,
                  sd_initialized, currentROM,
                  input  selectedROM, doLoadRom, load_refused, menu_busy);
  modport slave  (input  key_up, key_down, key_pgup, key_pgdn, key_enter,
                  sd_initialized, currentROM,
                  output selectedROM, doLoadRom, load_refused, menu_busy);
`endif
endinterface

// File: rtl/rom_menu_bcd.sv
// Iterative double-dabble: 16 shift cycles per conversion, restarted whenever bin changes.
// Only instantiated when ROM_MENU_BCD_EN is defined.
module rom_menu_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        valid
);

  logic [15:0] last;
  logic [15:0] shreg;
  logic [19:0] acc;
  logic [19:0] acc_adj;
  logic [4:0]  cnt;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // last resets to an unreachable index so a conversion of 0 starts straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last  <= 16'hFFFF;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      valid <= 1'b0;
    end else if (bin != last) begin
      last  <= bin;
      shreg <= bin;
      acc   <= '0;
      cnt   <= 5'd16;
      valid <= 1'b0;
    end else if (cnt != 5'd0) begin
      acc   <= {acc_adj[18:0], shreg[15]};
      shreg <= {shreg[14:0], 1'b0};
      cnt   <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        bcd   <= {acc_adj[18:0], shreg[15]};
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_menu_ctrl.sv
// ROM menu cursor and load-request sequencer for the ROM loader.
// Define ROM_MENU_BCD_EN to add the bcd_digits/bcd_valid readout.
//
// state  | meaning
// IDLE   | waiting for a key press
// HOLD   | nav key held, waiting REPEAT_DELAY before autorepeat
// REPEAT | nav key held, stepping every REPEAT_RATE cycles
// LOAD   | doLoadRom asserted for LOAD_CYCLES cycles
// DRAIN  | cursor frozen while loader latches, then wait enter release
import rom_menu_pkg::*;

module rom_menu_ctrl #(
  parameter logic [15:0] NUM_ROMS     = 16'd256,
  parameter logic [15:0] LOAD_CYCLES  = 16'd64,
  parameter logic [23:0] REPEAT_DELAY = 24'd8000000,
  parameter logic [23:0] REPEAT_RATE  = 24'd2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  rom_menu_if.slave  bus
);

  localparam logic [23:0] DELAY_TC = REPEAT_DELAY - 24'd1;
  localparam logic [23:0] RATE_TC  = REPEAT_RATE - 24'd1;
  localparam logic [23:0] LOAD_TC  = {8'd0, LOAD_CYCLES} - 24'd1;
  localparam logic [23:0] DRAIN_TC = 24'(DRAIN_CYCLES - 1);

  state_t      state, state_nx;
  logic [23:0] cnt, cnt_nx;
  logic [15:0] sel, sel_nx;
  logic        do_load, load_nx;
  logic        refused, refused_nx;
  logic        busy;
  logic [3:0]  held, held_nx;
  logic        repress, repress_nx;
  logic [4:0]  keys, keys_d, rise;
  logic [3:0]  nav;
  logic        nav_single;

  assign keys       = {bus.key_enter, bus.key_pgdn, bus.key_pgup, bus.key_down, bus.key_up};
  assign rise       = keys & ~keys_d;
  assign nav        = keys[3:0];
  assign nav_single = (nav != 4'd0) && ((nav & (nav - 4'd1)) == 4'd0);

  function automatic step_t key_code(input logic [3:0] k);
    if (k[0]) return STEP_P1;
    if (k[1]) return STEP_M1;
    if (k[2]) return STEP_P16;
    return STEP_M16;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sel     <= '0;
      do_load <= 1'b0;
      refused <= 1'b0;
      busy    <= 1'b0;
      held    <= '0;
      repress <= 1'b0;
      keys_d  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sel     <= sel_nx;
      do_load <= load_nx;
      refused <= refused_nx;
      busy    <= (state_nx != IDLE);
      held    <= held_nx;
      repress <= repress_nx;
      keys_d  <= keys;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sel_nx     = sel;
    load_nx    = do_load;
    refused_nx = 1'b0;
    held_nx    = held;
    repress_nx = repress;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rise[4]) begin
          repress_nx = 1'b0;
          if (bus.sd_initialized) begin
            state_nx = LOAD;
            load_nx  = 1'b1;
          end else begin
            refused_nx = 1'b1;
          end
        end else if (nav_single && (((rise[3:0] & nav) != 4'd0) || repress)) begin
          sel_nx     = step_rom(sel, key_code(nav), NUM_ROMS);
          held_nx    = nav;
          repress_nx = 1'b0;
          state_nx   = HOLD;
        end else if (nav == 4'd0) begin
          repress_nx = 1'b0;
        end
      end
      HOLD, REPEAT: begin
        if (nav == held) begin
          if (cnt == ((state == HOLD) ? DELAY_TC : RATE_TC)) begin
            sel_nx   = step_rom(sel, key_code(held), NUM_ROMS);
            cnt_nx   = '0;
            state_nx = REPEAT;
          end else begin
            cnt_nx = cnt + 24'd1;
          end
        end else begin
          // a newly pressed key has lost its edge by now; repress lets IDLE act on it
          state_nx   = IDLE;
          cnt_nx     = '0;
          repress_nx = ((nav & ~held) != 4'd0);
        end
      end
      LOAD: begin
        if (cnt == LOAD_TC) begin
          load_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = DRAIN;
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end
      DRAIN: begin
        if (cnt != DRAIN_TC) begin
          cnt_nx = cnt + 24'd1;
        end else if (!bus.key_enter) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.selectedROM  = sel;
  assign bus.doLoadRom    = do_load;
  assign bus.load_refused = refused;
  assign bus.menu_busy    = busy;

`ifdef ROM_MENU_BCD_EN
  rom_menu_bcd u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (sel),
    .bcd   (bus.bcd_digits),
    .valid (bus.bcd_valid)
  );
`endif

endmodule

// File: tb/tb_rom_menu_ctrl.sv
// Directed bench for rom_menu_ctrl: modulo-arithmetic cursor model checked every cycle,
// plus literal expectations at key points.
module tb_rom_menu_ctrl;

  localparam int N  = 20;
  localparam int LC = 16;
  localparam int RD = 100;
  localparam int RR = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_menu_if bus ();

  rom_menu_ctrl #(
    .NUM_ROMS     (16'(N)),
    .LOAD_CYCLES  (16'(LC)),
    .REPEAT_DELAY (24'(RD)),
    .REPEAT_RATE  (24'(RR))
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int exp_sel = 0;
  bit exp_load = 1'b0;
  bit exp_ref = 1'b0;
  bit exp_busy = 1'b0;
  int load_hi = 0;

  function automatic int mstep(int s, int d);
    return ((s + d) % N + N) % N;
  endfunction

  always @(negedge clk) begin
    tests++;
    if (bus.selectedROM !== 16'(exp_sel) || bus.doLoadRom !== exp_load ||
        bus.load_refused !== exp_ref || bus.menu_busy !== exp_busy) begin
      fails++;
      if (fails <= 20)
        $display("FAIL cycle_cmp t=%0t: got sel=%0d load=%b ref=%b busy=%b, want sel=%0d load=%b ref=%b busy=%b",
                 $time, bus.selectedROM, bus.doLoadRom, bus.load_refused, bus.menu_busy,
                 exp_sel, exp_load, exp_ref, exp_busy);
    end
    if (bus.doLoadRom === 1'b1) load_hi++;
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nav(input int which, input logic v);
    case (which)
      0: bus.key_up   = v;
      1: bus.key_down = v;
      2: bus.key_pgup = v;
      default: bus.key_pgdn = v;
    endcase
  endtask

  function automatic int delta(input int which);
    case (which)
      0: return 1;
      1: return -1;
      2: return 16;
      default: return -16;
    endcase
  endfunction

  task automatic pulse_nav(input int which);
    set_nav(which, 1'b1);
    tick();
    exp_sel  = mstep(exp_sel, delta(which));
    exp_busy = 1'b1;
    set_nav(which, 1'b0);
    tick();
    exp_busy = 1'b0;
  endtask

  initial begin
    bus.key_up = 1'b0;
    bus.key_down = 1'b0;
    bus.key_pgup = 1'b0;
    bus.key_pgdn = 1'b0;
    bus.key_enter = 1'b0;
    bus.sd_initialized = 1'b1;
    bus.currentROM = 16'd0;
    #2;
    check("reset_sel",  int'(bus.selectedROM), 0);
    check("reset_load", int'(bus.doLoadRom), 0);
    check("reset_ref",  int'(bus.load_refused), 0);
    check("reset_busy", int'(bus.menu_busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    pulse_nav(1); check("wrap_down", int'(bus.selectedROM), 19);
    pulse_nav(0); check("wrap_up",   int'(bus.selectedROM), 0);
    pulse_nav(2); check("pgup_0",    int'(bus.selectedROM), 16);
    pulse_nav(2); check("pgup_16",   int'(bus.selectedROM), 12);
    pulse_nav(3); check("pgdn_12",   int'(bus.selectedROM), 16);
    repeat (6) pulse_nav(1);
    check("down_x6", int'(bus.selectedROM), 10);
    pulse_nav(2); check("pgup_wrap", int'(bus.selectedROM), 6);
    pulse_nav(3); check("pgdn_wrap", int'(bus.selectedROM), 10);

    // two nav keys together: no step
    bus.key_up = 1'b1; bus.key_down = 1'b1;
    tick(); tick();
    bus.key_up = 1'b0; bus.key_down = 1'b0;
    tick();
    check("two_keys", int'(bus.selectedROM), 10);

    // enter outranks up; with no SD card the load is refused
    bus.sd_initialized = 1'b0;
    bus.key_enter = 1'b1; bus.key_up = 1'b1;
    tick();
    exp_ref = 1'b1;
    check("refused_noload", int'(bus.doLoadRom), 0);
    bus.key_enter = 1'b0; bus.key_up = 1'b0;
    tick();
    exp_ref = 1'b0;
    check("refused_sel", int'(bus.selectedROM), 10);
    bus.sd_initialized = 1'b1;

    repeat (10) pulse_nav(0);
    check("up_x10", int'(bus.selectedROM), 0);

    // hold-to-autorepeat
    bus.key_up = 1'b1;
    for (int j = 0; j < 150; j++) begin
      tick();
      if (j == 0 || (j >= RD && (j - RD) % RR == 0)) exp_sel = mstep(exp_sel, 1);
      exp_busy = 1'b1;
    end
    bus.key_up = 1'b0;
    tick();
    exp_busy = 1'b0;
    check("hold_repeat", int'(bus.selectedROM), 6);
    pulse_nav(1);
    check("sel_5", int'(bus.selectedROM), 5);

    // enter held 500 cycles, key_up tapped during LOAD
    load_hi = 0;
    bus.key_enter = 1'b1;
    for (int j = 0; j < 500; j++) begin
      tick();
      exp_load = (j < LC);
      exp_busy = 1'b1;
      if (j == 3) bus.key_up = 1'b1;
      if (j == 5) bus.key_up = 1'b0;
    end
    bus.key_enter = 1'b0;
    tick();
    exp_busy = 1'b0;
    check("load_len_held", load_hi, LC);
    check("load_sel", int'(bus.selectedROM), 5);

    // short enter; SD drops mid-pulse, pulse and drain still run to completion
    load_hi = 0;
    bus.key_enter = 1'b1;
    for (int j = 0; j < LC + 10; j++) begin
      tick();
      exp_load = (j < LC);
      exp_busy = (j < LC + 8);
      if (j == 0) bus.key_enter = 1'b0;
      if (j == 3) bus.sd_initialized = 1'b0;
    end
    check("load_len_short", load_hi, LC);
    bus.sd_initialized = 1'b1;

    // async reset mid-LOAD
    bus.key_enter = 1'b1;
    tick();
    exp_load = 1'b1; exp_busy = 1'b1;
    bus.key_enter = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    exp_sel = 0; exp_load = 1'b0; exp_busy = 1'b0;
    #1;
    check("rst_mid_load", int'(bus.doLoadRom), 0);
    check("rst_mid_sel",  int'(bus.selectedROM), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", int'(bus.menu_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
